ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//  Hazard and forwarding controller for the EX stage of the 5-stage MIPS pipeline.
//  Tracks destination registers of instructions in EX/MEM/WB and drives EX forwarding selects (aluselectA/B).
//  Requests load-use stalls and bubbles, and holds EX for multi-cycle ALU ops.
//  Sits beside the decode stage; outputs feed the IF/ID enable, the EX register enable and the EX bubble mux.
// PARAMETERS
//  MC_LATENCY  4  cycles a multi-cycle op occupies EX; legal range 2..15
//  RA_W        5  register address width
// PORTS
//  clk            in   1     rising-edge clock
//  rst_n          in   1     synchronous reset, active-low
//  id_valid       in   1     ID holds a real instruction (0 = flushed/empty)
//  id_rs, id_rt   in   RA_W  source register addresses of ID instruction
//  id_uses_rs     in   1     ID instruction reads rs
//  id_uses_rt     in   1     ID instruction reads rt
//  id_rw          in   RA_W  destination register of ID instruction
//  id_regwrite    in   1     ID instruction writes a register
//  id_memtoreg    in   1     ID instruction is a load
//  id_multicycle  in   1     ID instruction is a multi-cycle ALU op
//  aluselectA     out  2     EX operand A source: 0 BusA, 1 priorALUresult, 2 ALUwriteback
//  aluselectB     out  2     EX operand B source, same encoding (3 never driven)
//  stall          out  1     hold PC and IF/ID this cycle
//  bubble         out  1     load zeroed controls into EX register at next edge
//  ex_hold        out  1     EX register keeps its contents at next edge
//  mc_busy        out  1     multi-cycle op occupying EX with hold pending
// BEHAVIOUR
//  Reset (rst_n=0 at edge): EX/MEM/WB trackers empty (regwrite=0, rw=0); counter=0.
//  Reset outputs: aluselectA/B=0, ex_hold=0, mc_busy=0. stall=0 and bubble=0 while trackers are empty.
//  Trackers: each holds {rw, regwrite, memtoreg}.
//  Normal edge: EX<=ID (or empty if bubble or !id_valid), MEM<=EX, WB<=MEM.
//  Hold edge: EX unchanged, MEM<=empty, WB<=MEM.
//  Match(r, stage) = stage.regwrite && stage.rw==r && r!=0. Register 0 is never forwarded or stalled on.
//  aluselect is registered, computed in ID for the instruction entering EX. Per used operand:
//    - Match EX tracker -> 1.
//    - Else Match MEM tracker -> 2.
//    - Else 0.
//    - EX has priority over MEM. An unused operand gets 0.
//  Load-use: id_valid, EX tracker memtoreg, and Match on a used operand -> stall=1, bubble=1 (1 cycle, combinational).
//    The next cycle selects 2 for that operand.
//  Multi-cycle: issuing id_multicycle (not stalled) loads counter=MC_LATENCY-1.
//    ex_hold=mc_busy=stall=(counter!=0); bubble=0; counter decrements each cycle to 0.
//    EX is occupied MC_LATENCY cycles; the op advances to MEM on the edge where counter==0.
//  During hold, aluselectA/B are forced 0 because the unit latched its operands in its first EX cycle.
//    The ID instruction is re-evaluated every cycle.
//  Priority: reset > multi-cycle hold > load-use > normal. A load-use while held is evaluated after hold ends.
//  A dependent instruction following a multi-cycle op forwards from priorALUresult (select 1) normally.
//  id_valid=0: no stall, no bubble request; EX tracker loads empty.
//  Reset mid-hold: counter cleared; ex_hold drops on the following cycle.
// CONFIGURATION
//  HAZ_STATS_EN defined: adds outputs stall_cycles[31:0] and load_use_cnt[31:0].
//    stall_cycles counts every cycle with stall=1; load_use_cnt counts load-use events.
//    Both reset to 0 and wrap at 2^32.
//  HAZ_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.
// TESTING
//  add r3 <- r1,r2 then sub r4 <- r3,r5 -> sub in EX sees aluselectA=1, aluselectB=0, no stall.
//  add r3; nop; or r6 <- r7,r3 -> or in EX sees aluselectB=2.
//    With r3 also written by an instruction in EX, aluselect=1 wins.
//  lw r8; add r9 <- r8,r8 -> one cycle stall=1, bubble=1.
//    Then add enters EX with aluselectA=aluselectB=2.
//  Writes to r0 followed by a reader of r0 -> aluselect=0, no stall.
//  mult (MC_LATENCY=4) then dependent add -> ex_hold/stall high 3 cycles.
//    Then add enters EX next with aluselect=1.
//  rst_n=0 during hold -> next cycle all outputs 0.
//    With HAZ_STATS_EN: 2 load-use events give load_use_cnt=2 and stall_cycles=2.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard/forwarding controller: registered aluselect, combinational load-use stall/bubble, multi-cycle EX hold.
// Optional HAZ_STATS_EN adds stall_cycles / load_use_cnt counters.
module ex_hazard_ctrl #(
    parameter int MC_LATENCY = 4,
    parameter int RA_W       = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [RA_W-1:0] id_rw,
    input  logic            id_regwrite,
    input  logic            id_memtoreg,
    input  logic            id_multicycle,
    output logic [1:0]      aluselectA,
    output logic [1:0]      aluselectB,
    output logic            stall,
    output logic            bubble,
    output logic            ex_hold,
    output logic            mc_busy
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     load_use_cnt
`endif
);

    // WB writes land in the register file before ID reads it, so only EX and MEM
    // destinations can produce a forward or stall; the WB copy is not kept.
    logic [RA_W-1:0] ex_rw, mem_rw;
    logic            ex_wr, ex_ld, mem_wr;
    logic [3:0]      cnt;

    logic            hold;
    logic            lu_a, lu_b, load_use;
    logic [1:0]      sel_a, sel_b;

    function automatic logic hit(input logic [RA_W-1:0] r, input logic wr,
                                 input logic [RA_W-1:0] rw);
        return wr && (rw == r) && (r != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic used, input logic [RA_W-1:0] r,
                                           input logic exw, input logic [RA_W-1:0] exr,
                                           input logic memw, input logic [RA_W-1:0] memr);
        if (!used)                 return 2'd0;
        else if (hit(r, exw, exr)) return 2'd1;
        else if (hit(r, memw, memr)) return 2'd2;
        else                       return 2'd0;
    endfunction

    always_comb begin
        hold     = (cnt != 4'd0);
        lu_a     = id_uses_rs && hit(id_rs, ex_wr, ex_rw);
        lu_b     = id_uses_rt && hit(id_rt, ex_wr, ex_rw);
        load_use = !hold && id_valid && ex_ld && (lu_a || lu_b);
        sel_a    = fwd_sel(id_uses_rs, id_rs, ex_wr, ex_rw, mem_wr, mem_rw);
        sel_b    = fwd_sel(id_uses_rt, id_rt, ex_wr, ex_rw, mem_wr, mem_rw);
    end

    assign stall   = hold || load_use;
    assign bubble  = load_use;
    assign ex_hold = hold;
    assign mc_busy = hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_rw      <= '0;
            ex_wr      <= 1'b0;
            ex_ld      <= 1'b0;
            mem_rw     <= '0;
            mem_wr     <= 1'b0;
            cnt        <= 4'd0;
            aluselectA <= 2'd0;
            aluselectB <= 2'd0;
        end else if (hold) begin
            // EX keeps the multi-cycle op; operands were already captured, so selects drop to 0.
            cnt        <= cnt - 4'd1;
            mem_rw     <= '0;
            mem_wr     <= 1'b0;
            aluselectA <= 2'd0;
            aluselectB <= 2'd0;
        end else begin
            mem_rw <= ex_rw;
            mem_wr <= ex_wr;
            if (load_use || !id_valid) begin
                ex_rw      <= '0;
                ex_wr      <= 1'b0;
                ex_ld      <= 1'b0;
                aluselectA <= 2'd0;
                aluselectB <= 2'd0;
                cnt        <= 4'd0;
            end else begin
                ex_rw      <= id_rw;
                ex_wr      <= id_regwrite;
                ex_ld      <= id_memtoreg;
                aluselectA <= sel_a;
                aluselectB <= sel_b;
                cnt        <= id_multicycle ? 4'(MC_LATENCY - 1) : 4'd0;
            end
        end
    end

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
            load_use_cnt <= 32'd0;
        end else begin
            if (stall)    stall_cycles <= stall_cycles + 32'd1;
            if (load_use) load_use_cnt <= load_use_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Randomized bench for ex_hazard_ctrl against an instruction-level pipeline model.
module tb_ex_hazard_ctrl;
    localparam int MC   = 4;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memtoreg, id_multicycle;
    logic [RA_W-1:0] id_rs, id_rt, id_rw;
    logic [1:0]      aluselectA, aluselectB;
    logic            stall, bubble, ex_hold, mc_busy;
`ifdef HAZ_STATS_EN
    logic [31:0]     stall_cycles, load_use_cnt;
`endif

    ex_hazard_ctrl #(.MC_LATENCY(MC), .RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rw(id_rw), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
        .id_multicycle(id_multicycle),
        .aluselectA(aluselectA), .aluselectB(aluselectB),
        .stall(stall), .bubble(bubble), .ex_hold(ex_hold), .mc_busy(mc_busy)
`ifdef HAZ_STATS_EN
        , .stall_cycles(stall_cycles), .load_use_cnt(load_use_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rw;
        bit wr;
        bit ld;
        bit mc;
    } ins_t;

    ins_t in_ex, in_mem;
    int   ex_age;
    int   exp_sa, exp_sb;
    int   m_stall_cnt, m_lu_cnt;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t empty_ins();
        ins_t e;
        e.v = 0; e.rw = 0; e.wr = 0; e.ld = 0; e.mc = 0;
        return e;
    endfunction

    // Nearest older stage writing r: 1 = EX, 2 = MEM, 0 = none.
    function automatic int producer(input int r);
        if (r == 0) return 0;
        if (in_ex.v && in_ex.wr && in_ex.rw == r) return 1;
        if (in_mem.v && in_mem.wr && in_mem.rw == r) return 2;
        return 0;
    endfunction

    function automatic bit m_hold();
        return in_ex.v && in_ex.mc && (ex_age < MC - 1);
    endfunction

    function automatic bit m_load_use();
        bit dep;
        dep = (id_uses_rs && producer(int'(id_rs)) == 1) ||
              (id_uses_rt && producer(int'(id_rt)) == 1);
        return !m_hold() && id_valid && in_ex.ld && dep;
    endfunction

    task automatic model_reset();
        in_ex = empty_ins(); in_mem = empty_ins();
        ex_age = 0; exp_sa = 0; exp_sb = 0;
        m_stall_cnt = 0; m_lu_cnt = 0;
    endtask

    task automatic model_edge();
        bit   h, lu;
        ins_t nx;
        if (!rst_n) begin
            model_reset();
            return;
        end
        h  = m_hold();
        lu = m_load_use();
        if (h || lu) m_stall_cnt++;
        if (lu)      m_lu_cnt++;
        if (h) begin
            ex_age++;
            in_mem = empty_ins();
            exp_sa = 0; exp_sb = 0;
        end else begin
            if (lu || !id_valid) begin
                exp_sa = 0; exp_sb = 0;
                nx = empty_ins();
            end else begin
                exp_sa = id_uses_rs ? producer(int'(id_rs)) : 0;
                exp_sb = id_uses_rt ? producer(int'(id_rt)) : 0;
                nx.v = 1; nx.rw = int'(id_rw); nx.wr = id_regwrite;
                nx.ld = id_memtoreg; nx.mc = id_multicycle;
            end
            in_mem = in_ex;
            in_ex  = nx;
            ex_age = 0;
        end
    endtask

    task automatic drive_random();
        int kind;
        rst_n      = ($urandom_range(0, 63) != 0);
        id_valid   = ($urandom_range(0, 7) != 0);
        id_rs      = RA_W'($urandom_range(0, 3));
        id_rt      = RA_W'($urandom_range(0, 3));
        id_rw      = RA_W'($urandom_range(0, 3));
        id_uses_rs = ($urandom_range(0, 3) != 0);
        id_uses_rt = ($urandom_range(0, 3) != 0);
        kind       = $urandom_range(0, 7);
        id_memtoreg   = (kind < 2);
        id_multicycle = (kind == 2);
        id_regwrite   = id_memtoreg || ($urandom_range(0, 3) != 0);
    endtask

    task automatic check_outputs();
        bit h, lu;
        h  = m_hold();
        lu = m_load_use();
        check("aluselectA", 32'(aluselectA), 32'(exp_sa));
        check("aluselectB", 32'(aluselectB), 32'(exp_sb));
        check("stall",      32'(stall),      32'(h || lu));
        check("bubble",     32'(bubble),     32'(lu));
        check("ex_hold",    32'(ex_hold),    32'(h));
        check("mc_busy",    32'(mc_busy),    32'(h));
`ifdef HAZ_STATS_EN
        check("stall_cycles", stall_cycles, 32'(m_stall_cnt));
        check("load_use_cnt", load_use_cnt, 32'(m_lu_cnt));
`endif
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rw = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_regwrite = 1'b0;
        id_memtoreg = 1'b0; id_multicycle = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        #1;
        check_outputs();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            drive_random();
            #1;
            check_outputs();
            @(posedge clk);
            model_edge();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
